adc_sample_sequencer: RTL

- Sequences periodic conversions from the board temperature ADC over a req/ack handshake.
- Averages 2^AVG_LOG2 samples and presents a filtered 12-bit code with a one-cycle valid strobe.
- Sits between the ADC interface and temp_to_led; its adc_dout output drives temp_to_led's adc_dout input directly.
- Rate-limits ADC traffic so the LED bar updates at a steady, debounced rate.

---
 rtl/adc_sample_sequencer_if.sv | 29 ++
 rtl/adc_sample_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer_if.sv
// ADC-side handshake and filtered-output bundle for adc_sample_sequencer.
// master = sequencer, slave = ADC interface / temp_to_led side.
interface adc_sample_sequencer_if;
    // Handshake: adc_req rises and then stays high until the first cycle with
    // adc_ack=1. adc_data is valid only in that ack cycle. adc_req drops the
    // cycle after. An ack while adc_req=0 is ignored. dout_valid is a
    // one-cycle strobe that qualifies a new adc_dout.
    logic        adc_req;
    logic        adc_ack;
    logic [11:0] adc_data;
    logic [11:0] adc_dout;
    logic        dout_valid;

    modport master (
        output adc_req,
        input  adc_ack,
        input  adc_data,
        output adc_dout,
        output dout_valid
    );

    modport slave (
        input  adc_req,
        output adc_ack,
        output adc_data,
        input  adc_dout,
        input  dout_valid
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC conversion sequencer with a 2^AVG_LOG2 boxcar average.
// Optional REQ timeout is built when the macro ADC_TIMEOUT_EN is defined.
module adc_sample_sequencer #(
    parameter int SAMPLE_DIV  = 50000,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clr_flags,
    adc_sample_sequencer_if.master bus,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic [1:0]             dbg_state
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(1 << AVG_LOG2);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_TICK = 2'd1;
    localparam logic [1:0] REQ       = 2'd2;
    localparam logic [1:0] OUT       = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          ack_seen;
    logic          expire;

    assign tick      = enable && (tick_cnt == TICK_LAST);
    assign ack_seen  = (state == REQ) && bus.adc_ack;
    assign acc_sum   = acc + AW'(bus.adc_data);
    assign cnt_next  = cnt + CW'(1);
    assign dbg_state = state;

`ifdef ADC_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYC + 1);
    logic [OW-1:0] req_cyc;

    // An ack landing on the expiry cycle wins over the timeout.
    assign expire = (state == REQ) && !bus.adc_ack
                    && (req_cyc == OW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != REQ) begin
            req_cyc <= '0;
        end else begin
            req_cyc <= req_cyc + OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end else if (clr_flags) begin
            timeout_err <= 1'b0;
        end
    end
`else
    assign expire = 1'b0;
    // Constant 0 for any legal TIMEOUT_CYC; the timeout only exists in the other build.
    assign timeout_err = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            acc            <= '0;
            cnt            <= '0;
            overrun        <= 1'b0;
            bus.adc_req    <= 1'b0;
            bus.adc_dout   <= 12'hFFF;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;

            if (!enable || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            // A tick during an outstanding request is dropped, only flagged.
            if (state == REQ && tick) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (tick) begin
                        state       <= REQ;
                        bus.adc_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_seen) begin
                        bus.adc_req <= 1'b0;
                        if (!enable) begin
                            state <= IDLE;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            acc   <= acc_sum;
                            cnt   <= cnt_next;
                            state <= (cnt_next == CNT_FULL) ? OUT : WAIT_TICK;
                        end
                    end else if (expire) begin
                        bus.adc_req <= 1'b0;
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= enable ? WAIT_TICK : IDLE;
                    end
                end
                OUT: begin
                    bus.adc_dout   <= acc[AVG_LOG2 +: 12];
                    bus.dout_valid <= 1'b1;
                    acc            <= '0;
                    cnt            <= '0;
                    state          <= enable ? WAIT_TICK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
